// File: rtl/io_pkg.sv
// Shared constants for the CPU-side IO bridge: window base, register offsets,
// scan defaults and the active-low seven-segment hex table.
package io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT  = 32'hFFFF_F000;
    localparam int unsigned SCAN_DIV_DEFAULT = 50000;

    localparam logic [11:0] OFF_SEG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;

    // {dp,g..a} active-low patterns, entry 15 first.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [2:0] {
        REG_NONE,
        REG_SEG,
        REG_TIMER,
        REG_LED,
        REG_SW
    } io_reg_e;

    function automatic io_reg_e decode_offset(input logic [11:0] offset);
        case (offset)
            OFF_SEG:   return REG_SEG;
            OFF_TIMER: return REG_TIMER;
            OFF_LED:   return REG_LED;
            OFF_SW:    return REG_SW;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex digit to active-low seven-segment pattern, dp off.
module seg_decoder
    import io_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg_n
);

    assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge between the CPU data port, the data RAM and board IO
// (SEG, LED, SW, optional TIMER). Define IO_TIMER_EN to build the TIMER register.
module io_bridge
    import io_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic        wen,
    output logic [31:0] rData,
    output logic [13:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic        dram_we,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_cx
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic        io_hit;
    io_reg_e     reg_sel;

    logic [31:0] seg_d, seg_q;
    logic [23:0] led_d, led_q;
    logic [23:0] sw_meta_d, sw_meta_q;
    logic [23:0] sw_sync_d, sw_sync_q;
    logic [15:0] div_d, div_q;
    logic [2:0]  idx_d, idx_q;
    logic [7:0]  seg_en_d, seg_en_q;
    logic [7:0]  seg_cx_d, seg_cx_q;
    logic [31:0] timer_rd;

    logic [3:0]  digit_hex;
    logic [7:0]  digit_seg;

    assign io_hit  = (addr[31:12] == IO_BASE[31:12]);
    assign reg_sel = io_hit ? decode_offset(addr[11:0]) : REG_NONE;

    assign dram_addr  = addr[15:2];
    assign dram_wdata = wData;
    assign dram_we    = wen & ~io_hit;

    assign led    = led_q;
    assign seg_en = seg_en_q;
    assign seg_cx = seg_cx_q;

    assign digit_hex = seg_q[{idx_q, 2'b00} +: 4];

    seg_decoder u_seg_decoder (
        .hex   (digit_hex),
        .seg_n (digit_seg)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        seg_d     = seg_q;
        led_d     = led_q;
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        div_d     = div_q + 16'd1;
        idx_d     = idx_q;

        if (wen && reg_sel == REG_SEG) seg_d = wData;
        if (wen && reg_sel == REG_LED) led_d = wData[23:0];

        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Display outputs follow the current slot one edge later.
        seg_en_d = ~(8'h01 << idx_q);
        seg_cx_d = digit_seg;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop updates from the same pre-edge values.
        if (rst) begin
            seg_q     <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_en_q  <= 8'hFE;
            seg_cx_q  <= 8'hC0;
        end else begin
            seg_q     <= seg_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_cx_q  <= seg_cx_d;
        end
    end

`ifdef IO_TIMER_EN
    logic [31:0] timer_d, timer_q;

    // A store in the same cycle replaces the increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wen && reg_sel == REG_TIMER) timer_d = wData;
    end

    always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        rData = dram_rdata;
        if (io_hit) begin
            case (reg_sel)
                REG_SEG:   rData = seg_q;
                REG_TIMER: rData = timer_rd;
                REG_LED:   rData = {8'h00, led_q};
                REG_SW:    rData = {8'h00, sw_sync_q};
                default:   rData = '0;
            endcase
        end
    end

endmodule
